// File: rtl/latch_write_sequencer.sv
// Drives a level-sensitive latch bank: captures a word over valid/ready, then
// sequences D/EN through setup, enable pulse and hold. Readback: LATCH_READBACK_EN.
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] D,
    output logic             EN,
    input  logic [WIDTH-1:0] Q_FB,
    output logic             DONE,
    output logic             ERR
);

    if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
        $error("SETUP_CYC must be in 1..255");
    end
    if (EN_CYC < 1 || EN_CYC > 255) begin : g_bad_en
        $error("EN_CYC must be in 1..255");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
        $error("HOLD_CYC must be in 1..255");
    end

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] EN_LOAD    = 8'(EN_CYC - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        en_d    = en_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    d_d     = IN_DATA;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    en_d    = 1'b1;
                    cnt_d   = EN_LOAD;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    en_d    = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef LATCH_READBACK_EN
                    // Last cycle of hold: the latch has had the full pulse to settle.
                    if (Q_FB != d_q) err_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            d_q     <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign IN_READY = (state_q == IDLE) && !RST;
    assign D        = d_q;
    assign EN       = en_q;
    assign DONE     = done_q;

`ifdef LATCH_READBACK_EN
    assign ERR = err_q;
`else
    // Without readback the feedback path and error flop have no observers.
    logic unused_fb;
    assign unused_fb = ^{Q_FB, err_q};
    assign ERR       = 1'b0;
`endif

endmodule
